// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register-bank completer.
package apb_pkg;

  // IDLE and ACCESS are held in the state register. SETUP is the cycle where the bus presents
  // PSEL=1/PENABLE=0 while the completer is idle, so it is decoded from IDLE and never stored.
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam logic APB_OKAY  = 1'b0;
  localparam logic APB_ERROR = 1'b1;

  // Number of byte lanes on the data bus.
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Width of a register index; at least one bit.
  function automatic int unsigned idx_width(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/apb_reg_file.sv
// Register array with a byte-strobed write port and a combinational read port.
// Index 0 is a constant ID word and ignores writes.
module apb_reg_file
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ID_VALUE   = 'hA5
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               we_i,
  input  logic [idx_width(NUM_REGS)-1:0]     widx_i,
  input  logic [DATA_WIDTH-1:0]              wdata_i,
  input  logic [strb_width(DATA_WIDTH)-1:0]  wstrb_i,
  input  logic [idx_width(NUM_REGS)-1:0]     ridx_i,
  output logic [DATA_WIDTH-1:0]              rdata_o
);

  localparam int unsigned StrbW = strb_width(DATA_WIDTH);
  localparam int unsigned IdxW  = idx_width(NUM_REGS);

  logic [DATA_WIDTH-1:0] words [NUM_REGS];

  assign words[0] = DATA_WIDTH'(ID_VALUE);

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_WIDTH-1:0] reg_q;

    // Update only the byte lanes enabled by the strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        reg_q <= '0;
      end else if (we_i && (widx_i == IdxW'(i))) begin
        for (int b = 0; b < StrbW; b++) begin
          if (wstrb_i[b]) begin
            reg_q[b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end
    end

    assign words[i] = reg_q;
  end

  assign rdata_o = words[ridx_i];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB4 completer in front of a register bank: address decode, wait-state counter and
// OKAY/ERROR response. The register storage lives in apb_reg_file.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ID_VALUE    = 'hA5
) (
  input  logic                              PCLK,
  input  logic                              PRESET,
  input  logic [ADDR_WIDTH-1:0]             PADDR,
  input  logic                              PSEL,
  input  logic                              PENABLE,
  input  logic                              PWRITE,
  input  logic [DATA_WIDTH-1:0]             PWDATA,
  input  logic [strb_width(DATA_WIDTH)-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]             PRDATA,
  output logic                              PREADY,
  output logic                              PSLVERR
);

  localparam int unsigned StrbW = strb_width(DATA_WIDTH);
  localparam int unsigned IdxW  = idx_width(NUM_REGS);

  apb_state_e             state_q, state_d, cur_st;
  logic [3:0]             wait_q, wait_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   err_q, err_d;
  logic                   write_q, write_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [StrbW-1:0]       strb_q, strb_d;

  logic [ADDR_WIDTH-1:0]  offset, word_off;
  logic                   dec_aligned, dec_in_range;
  logic                   ready, commit;
  logic [DATA_WIDTH-1:0]  rf_rdata;

  // Address decode of the live bus address; only captured in SETUP.
  always_comb begin
    offset       = PADDR - ADDR_WIDTH'(BASE_ADDR);
    word_off     = offset / ADDR_WIDTH'(StrbW);
    dec_aligned  = (offset % ADDR_WIDTH'(StrbW)) == '0;
    dec_in_range = (PADDR >= ADDR_WIDTH'(BASE_ADDR)) && (word_off < ADDR_WIDTH'(NUM_REGS));
  end

  // SETUP is recognised from IDLE by the bus phase itself so PREADY can rise in cycle 2.
  always_comb begin
    cur_st = state_q;
    if ((state_q == IDLE) && PSEL && !PENABLE) begin
      cur_st = SETUP;
    end
  end

  // Next-state logic: latch the transfer in SETUP, count wait states in ACCESS.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    err_d   = err_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    unique case (cur_st)
      IDLE: begin
        state_d = IDLE;
      end
      SETUP: begin
        idx_d   = word_off[IdxW-1:0];
        err_d   = !dec_in_range || !dec_aligned || (PWRITE && (word_off == '0));
        write_d = PWRITE;
        wdata_d = PWDATA;
        strb_d  = PSTRB;
        wait_d  = 4'(WAIT_STATES);
        state_d = ACCESS;
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          if (wait_q != '0) begin
            wait_d = wait_q - 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched transfer registers.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q <= IDLE;
      wait_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  assign ready  = (state_q == ACCESS) && PSEL && PENABLE && (wait_q == '0);
  assign commit = ready && !err_q && write_q;

  apb_reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE)
  ) u_reg_file (
    .clk_i   (PCLK),
    .rst_ni  (PRESET),
    .we_i    (commit),
    .widx_i  (idx_q),
    .wdata_i (wdata_q),
    .wstrb_i (strb_q),
    .ridx_i  (idx_q),
    .rdata_o (rf_rdata)
  );

  // Response: read data only in the completing cycle of a good read.
  always_comb begin
    PREADY  = ready;
    PSLVERR = ready ? err_q : APB_OKAY;
    PRDATA  = (ready && !write_q && (err_q == APB_OKAY)) ? rf_rdata : '0;
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: three instances (8-bit default, 8-bit with three
// wait states, 32-bit at base 0x100) share one bus and are selected by their own PSEL.
module tb_apb_slave_regbank;
  import apb_pkg::*;

  logic        clk = 1'b0;
  logic        preset;
  logic [15:0] paddr;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic [7:0]  prdata_d8, prdata_w3;
  logic [31:0] prdata_d32;
  logic        pready_d8, pready_w3, pready_d32;
  logic        pslverr_d8, pslverr_w3, pslverr_d32;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_slave_regbank u_d8 (
    .PCLK (clk), .PRESET (preset), .PADDR (paddr), .PSEL (psel[0]), .PENABLE (penable),
    .PWRITE (pwrite), .PWDATA (pwdata[7:0]), .PSTRB (pstrb[0:0]), .PRDATA (prdata_d8),
    .PREADY (pready_d8), .PSLVERR (pslverr_d8)
  );

  apb_slave_regbank #(.WAIT_STATES (3)) u_w3 (
    .PCLK (clk), .PRESET (preset), .PADDR (paddr), .PSEL (psel[1]), .PENABLE (penable),
    .PWRITE (pwrite), .PWDATA (pwdata[7:0]), .PSTRB (pstrb[0:0]), .PRDATA (prdata_w3),
    .PREADY (pready_w3), .PSLVERR (pslverr_w3)
  );

  apb_slave_regbank #(.DATA_WIDTH (32), .BASE_ADDR ('h100)) u_d32 (
    .PCLK (clk), .PRESET (preset), .PADDR (paddr), .PSEL (psel[2]), .PENABLE (penable),
    .PWRITE (pwrite), .PWDATA (pwdata), .PSTRB (pstrb), .PRDATA (prdata_d32),
    .PREADY (pready_d32), .PSLVERR (pslverr_d32)
  );

  function automatic logic rdy(input int d);
    return (d == 0) ? pready_d8 : (d == 1) ? pready_w3 : pready_d32;
  endfunction

  function automatic logic serr(input int d);
    return (d == 0) ? pslverr_d8 : (d == 1) ? pslverr_w3 : pslverr_d32;
  endfunction

  function automatic logic [31:0] rdat(input int d);
    return (d == 0) ? {24'h0, prdata_d8} : (d == 1) ? {24'h0, prdata_w3} : prdata_d32;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transfer, entered just after a rising edge. Address/data are scrambled during ACCESS
  // because the completer must use what it saw in SETUP. With b2b set the bus is left selected
  // so the next call starts its SETUP without an idle cycle.
  task automatic xfer(input int d, input logic wr, input logic [15:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input logic b2b,
                      output logic [31:0] rd, output logic err, output int lat, output int rcyc);
    int guard;
    psel    = 3'(1 << d);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    @(negedge clk);
    check("setup_ready_low", {31'h0, rdy(d)}, 32'h0);
    @(posedge clk); #1;
    penable = 1'b1;
    paddr   = ~addr;
    pwdata  = ~data;
    lat     = 2;
    guard   = 0;
    @(negedge clk);
    while (!rdy(d) && guard < 40) begin
      @(posedge clk); #1;
      lat++;
      guard++;
      @(negedge clk);
    end
    if (!rdy(d)) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: PREADY low after %0d cycles, required high", lat);
    end
    rd   = rdat(d);
    err  = serr(d);
    rcyc = cyc;
    @(posedge clk); #1;
    if (!b2b) begin
      psel    = '0;
      penable = 1'b0;
      pwrite  = 1'b0;
    end
  endtask

  task automatic do_read(input int d, input logic [15:0] addr, input logic [31:0] exp,
                         input logic exp_err, input string tag, output int lat);
    logic [31:0] rd;
    logic        err;
    int          rc;
    xfer(d, 1'b0, addr, 32'h0, 4'h0, 1'b0, rd, err, lat, rc);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
  endtask

  task automatic do_write(input int d, input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic exp_err, input string tag,
                          output int lat);
    logic [31:0] rd;
    logic        err;
    int          rc;
    xfer(d, 1'b1, addr, data, strb, 1'b0, rd, err, lat, rc);
    check({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
  endtask

  initial begin
    int          lat;
    int          rc1, rc2, rc3;
    logic [31:0] rd;
    logic        err;

    preset  = 1'b0;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pready", {31'h0, pready_d8}, 32'h0);
    check("rst_pslverr", {31'h0, pslverr_d8}, 32'h0);
    check("rst_prdata", {24'h0, prdata_d8}, 32'h0);
    @(posedge clk); #1;
    preset = 1'b1;
    @(posedge clk); #1;

    // Defaults and ID register
    do_read(0, 16'h0000, 32'hA5, 1'b0, "id_read", lat);
    check("id_read_lat", lat, 2);
    do_read(0, 16'h0001, 32'h00, 1'b0, "reg1_default", lat);

    // Plain write/read, zero and three wait states
    do_write(0, 16'h0005, 32'h3C, 4'h1, 1'b0, "wr5", lat);
    check("wr5_lat", lat, 2);
    do_read(0, 16'h0005, 32'h3C, 1'b0, "rd5", lat);
    do_write(1, 16'h0005, 32'h3C, 4'h1, 1'b0, "ws_wr5", lat);
    check("ws_wr5_lat", lat, 5);
    do_read(1, 16'h0005, 32'h3C, 1'b0, "ws_rd5", lat);
    check("ws_rd5_lat", lat, 5);

    // Error responses
    do_write(0, 16'h0000, 32'h99, 4'h1, 1'b1, "wr_id", lat);
    do_write(0, 16'h0010, 32'h99, 4'h1, 1'b1, "wr_oor", lat);
    do_read(0, 16'h0000, 32'hA5, 1'b0, "id_after_wr", lat);
    do_read(0, 16'h0010, 32'h00, 1'b1, "rd_oor", lat);

    // 32-bit instance: strobes, alignment, base offset
    do_write(2, 16'h0104, 32'hDEADBEEF, 4'b1111, 1'b0, "w32_full", lat);
    do_write(2, 16'h0104, 32'h11223344, 4'b0101, 1'b0, "w32_strb", lat);
    do_read(2, 16'h0104, 32'hDE22BE44, 1'b0, "r32_merge", lat);
    do_write(2, 16'h0104, 32'hFFFFFFFF, 4'b0000, 1'b0, "w32_nostrb", lat);
    do_read(2, 16'h0104, 32'hDE22BE44, 1'b0, "r32_nostrb", lat);
    do_read(2, 16'h0106, 32'h0, 1'b1, "r32_misalign", lat);
    do_read(2, 16'h00FC, 32'h0, 1'b1, "r32_below_base", lat);
    do_read(2, 16'h0100, 32'hA5, 1'b0, "r32_id", lat);

    // Back-to-back writes: one PREADY every two cycles
    xfer(0, 1'b1, 16'h0002, 32'h11, 4'h1, 1'b1, rd, err, lat, rc1);
    xfer(0, 1'b1, 16'h0003, 32'h22, 4'h1, 1'b1, rd, err, lat, rc2);
    xfer(0, 1'b1, 16'h0004, 32'h33, 4'h1, 1'b0, rd, err, lat, rc3);
    check("b2b_gap1", rc2 - rc1, 2);
    check("b2b_gap2", rc3 - rc2, 2);
    do_read(0, 16'h0002, 32'h11, 1'b0, "b2b_rd2", lat);
    do_read(0, 16'h0003, 32'h22, 1'b0, "b2b_rd3", lat);
    do_read(0, 16'h0004, 32'h33, 1'b0, "b2b_rd4", lat);

    // PSEL with PENABLE straight from idle is ignored
    psel    = 3'b001;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 16'h0008;
    pwdata  = 32'h5A;
    pstrb   = 4'h1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("viol_ready", {31'h0, pready_d8}, 32'h0);
      @(posedge clk); #1;
    end
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    do_read(0, 16'h0008, 32'h00, 1'b0, "viol_rd8", lat);

    // PSEL dropped in ACCESS: abort without write
    psel    = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 16'h0007;
    pwdata  = 32'h66;
    @(posedge clk); #1;
    psel    = '0;
    penable = 1'b1;
    @(negedge clk);
    check("abort_ready", {31'h0, pready_d8}, 32'h0);
    @(posedge clk); #1;
    penable = 1'b0;
    pwrite  = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'(u_d8.state_q), 32'(IDLE));
    @(posedge clk); #1;
    do_read(0, 16'h0007, 32'h00, 1'b0, "abort_rd7", lat);
    check("abort_rd7_lat", lat, 2);

    // Reset pulse during ACCESS of a write
    do_write(0, 16'h0006, 32'h99, 4'h1, 1'b0, "pre_rst_wr6", lat);
    do_read(0, 16'h0006, 32'h99, 1'b0, "pre_rst_rd6", lat);
    psel    = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 16'h0006;
    pwdata  = 32'h77;
    pstrb   = 4'h1;
    @(posedge clk); #1;
    preset  = 1'b0;
    penable = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", {31'h0, pready_d8}, 32'h0);
    @(posedge clk); #1;
    preset  = 1'b1;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_after", {31'h0, pready_d8}, 32'h0);
    @(posedge clk); #1;
    do_read(0, 16'h0006, 32'h00, 1'b0, "rst_mid_rd6", lat);
    do_read(0, 16'h0000, 32'hA5, 1'b0, "rst_mid_id", lat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute bound on the run
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
Parametrised APB4 completer fronting a bank of read/write registers, with programmable wait states, byte strobes and error response.
- Successor to the fixed 16-bit-address / 8-bit-data APB bus: generalises address width, data width and register depth.
- Adds PSTRB, PREADY stretching and PSLVERR generation.
- Sits behind the APB bus on PCLK. Also serves as the reference completer for the APB driver/monitor bench.

Parameters:
ADDR_WIDTH, 16, PADDR width
DATA_WIDTH, 8, PWDATA/PRDATA width; legal values 8, 16 or 32
NUM_REGS, 16, number of registers; power of 2, 2 to 256
BASE_ADDR, 0, byte address of register 0; aligned to DATA_WIDTH/8
WAIT_STATES, 0, extra ACCESS cycles before PREADY; 0 to 15
ID_VALUE, 'hA5, reset/constant value of register 0 (read-only ID)

Ports:
PCLK  input  1  clock; all logic on rising edge
PRESET  input  1  asynchronous reset, active-low
PADDR  input  ADDR_WIDTH  byte address
PSEL  input  1  completer select
PENABLE  input  1  access phase
PWRITE  input  1  1=write, 0=read
PWDATA  input  DATA_WIDTH  write data
PSTRB  input  DATA_WIDTH/8  write byte-lane enables
PRDATA  output  DATA_WIDTH  read data, valid when PREADY=1 and PWRITE=0
PREADY  output  1  transfer complete
PSLVERR  output  1  error, valid only when PREADY=1

Behaviour:
Reset (PRESET=0, asynchronous):
- State goes to IDLE.
- PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0.
- Registers 1..NUM_REGS-1 are cleared to 0.
- Register 0 is constant ID_VALUE and is never written.

State machine (three states):
- IDLE -> SETUP when PSEL=1 and PENABLE=0.
- PSEL=1 with PENABLE=1 in IDLE is a protocol violation: ignore it and stay in IDLE.
- SETUP:
  - Latch PADDR, PWRITE, PWDATA, PSTRB.
  - Compute decode result: index, in_range, aligned.
  - Load wait counter with WAIT_STATES.
  - -> ACCESS.
- ACCESS, PENABLE=1 and counter>0: decrement counter, PREADY=0.
- ACCESS, PENABLE=1 and counter=0: drive PREADY=1 combinationally for this cycle; commit the transfer at the clock edge.
  - Then -> SETUP if PSEL=1 and PENABLE=0 is sampled next cycle (back-to-back transfer).
  - Otherwise -> IDLE.
- ACCESS with PSEL=0 (abort): -> IDLE; no write, PREADY stays 0.

Latency:
- Minimum transfer is 2 cycles (SETUP + ACCESS) when WAIT_STATES=0.
- PREADY asserts in cycle 2+WAIT_STATES.
- PREADY is high for exactly one cycle per transfer.

Decode:
- offset = PADDR - BASE_ADDR, unsigned at ADDR_WIDTH bits.
- aligned = (offset mod (DATA_WIDTH/8)) == 0.
- index = offset / (DATA_WIDTH/8).
- in_range = PADDR >= BASE_ADDR and index < NUM_REGS.

Error (PSLVERR=1 with PREADY):
- !in_range, or !aligned, or write to index 0.
- An error write modifies nothing.
- An error read returns PRDATA=0.

Write commit:
- Only with PREADY=1, PSLVERR=0 and PWRITE=1.
- Byte lane b of the register updates iff PSTRB[b]=1.
- PSTRB=0 is a legal no-op write; it completes with PSLVERR=0.

Read:
- PRDATA is driven from the latched index during the final ACCESS cycle.
- PRDATA=0 in all other cycles.

Reset mid-transfer: immediate return to IDLE; no partial write.

PADDR/PWDATA changing during ACCESS: ignored, because the SETUP-latched values are used.

Decomposition:
- Package apb_pkg holds:
  - apb_state_e {IDLE, SETUP, ACCESS}.
  - Localparam function for strobe width (DATA_WIDTH/8).
  - Localparam function for clog2-based index width.
  - Constants APB_OKAY=0, APB_ERROR=1.
- Sub-module apb_reg_file holds the register array:
  - Byte-strobed write port; combinational read port.
  - Index 0 hardwired to ID_VALUE.
  - Parametrised by DATA_WIDTH, NUM_REGS, ID_VALUE.
- FSM, wait counter and decode stay in the top module.

Test Plan:
- Reset, then read addr 0x0000 (defaults) -> PREADY in cycle 2, PRDATA=0xA5, PSLVERR=0. Read addr 0x0001 -> PRDATA=0x00.
- Write 0x3C to 0x0005, then read 0x0005 -> PRDATA=0x3C. Repeat with WAIT_STATES=3 -> PREADY first high in cycle 5 of each transfer.
- Write to 0x0000, and write to 0x0010 (NUM_REGS=16) -> PSLVERR=1 with PREADY. Subsequent read of 0x0000 still returns 0xA5; read of 0x0010 returns PRDATA=0 with PSLVERR=1.
- DATA_WIDTH=32, BASE_ADDR=0x100:
  - Write 0xDEADBEEF to 0x104 with PSTRB=4'b1111, then write 0x11223344 with PSTRB=4'b0101 -> read 0x104 gives 0xDE22BE44.
  - Read 0x106 -> PSLVERR=1 (misaligned).
- Back-to-back writes to regs 2, 3, 4 with no IDLE cycle -> three PREADY pulses 2 cycles apart; all values read back correctly.
- PRESET low for one cycle during ACCESS of a write of 0x77 to reg 6 -> PREADY never asserts; reg 6 reads 0x00 afterward. Also: PSEL dropped in ACCESS -> no write, FSM in IDLE the next cycle.
